card_deck: RTL
==============

# card_deck

Shuffled 52-card deck dispenser for the blackjack game. It serves one-card draw requests from `blackjack_FSM` and returns a pseudo-random card that has not yet been dealt since the last shuffle, as rank, suit and blackjack point value. It sits directly upstream of `blackjack_FSM`/`calculate_card` and runs on the 65 MHz VGA-domain `clk`.

## Interface
Parameters:
- `SEED`, 16'hACE1: reset value of the LFSR. Must be non-zero.

Ports:
- `clk`  in  1  system clock, shared with the VGA pipeline.
- `rst`  in  1  reset. Synchronous, active-high.
- `shuffle`  in  1  single-cycle pulse. Returns all 52 cards to the deck.
- `draw_req`  in  1  single-cycle pulse. Requests one card.
- `card_valid`  out  1  one-cycle pulse. The card outputs are new.
- `card_rank`  out  4  1..13 (1 = ace, 11..13 = J/Q/K). Held until the next delivery.
- `card_suit`  out  2  0..3. Held until the next delivery.
- `card_value`  out  5  blackjack value: ace = 11, 2..10 = rank, J/Q/K = 10. Held.
- `busy`  out  1  high while a draw is in progress (SEARCH or DONE).
- `deck_empty`  out  1  high when `cards_left` == 0.
- `cards_left`  out  6  undealt cards, 0..52.

## Operation
- Internal state:
  - 52-bit `used` mask.
  - 6-bit probe index `idx`.
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1. It advances every cycle regardless of state.
- Card index mapping, for index i in 0..51:
  - suit = i/13, rank = (i mod 13)+1.
  - Implement by comparison against 13/26/39. No dividers.
- FSM states: IDLE, SEARCH, DONE.
- IDLE
  - Transitions to SEARCH on `draw_req` && !`deck_empty`.
  - On that transition, `idx` is loaded with `lfsr[5:0]`, minus 52 if ≥52 (values 52..63 map to 0..11).
  - `draw_req` while `deck_empty` is ignored. No state change, no `card_valid`.
- SEARCH checks one index per cycle:
  - If `used[idx]`==0: set `used[idx]`, latch rank/suit/value of `idx` into the output registers, decrement `cards_left`, go to DONE.
  - Otherwise: `idx` ← (`idx`==51) ? 0 : `idx`+1, and stay in SEARCH.
- DONE: `card_valid`=1 for exactly this cycle, then go to IDLE.
- `draw_req` while `busy` is ignored. It is not queued.
- `shuffle`, from any state:
  - Next cycle: `used` cleared, `cards_left`=52, FSM in IDLE.
  - An in-progress draw is aborted. No `card_valid`, and the card outputs keep their previous values.
  - `shuffle` and `draw_req` in the same cycle: shuffle wins and the draw is dropped.
- Arithmetic:
  - `cards_left` never underflows. The decrement happens only in SEARCH on a hit, and SEARCH is entered only when `cards_left`>0.
  - The wrap from 51 to 0 is explicit. `idx` never exceeds 51.

## Timing
- Reset values (synchronous `rst`=1 at a clock edge):
  - FSM IDLE, `used`=0, `cards_left`=52, `deck_empty`=0, `busy`=0.
  - `card_valid`=0, `card_rank`=0, `card_suit`=0, `card_value`=0.
  - LFSR=`SEED`.
- `rst` overrides `shuffle` and `draw_req`.
- Draw latency, with `draw_req` sampled at edge k:
  - SEARCH is active in cycle k+1.
  - Best case: `card_valid` is high in cycle k+2.
  - Worst case (51 used cards probed before the hit): `card_valid` in cycle k+53.
- Card outputs and `cards_left` update on the same edge that raises `card_valid`. They are stable from then on.
- `busy` rises the cycle after the accepted `draw_req` and falls the cycle after `card_valid`.
- `deck_empty` is registered and equals (`cards_left`==0) in the same cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles, holding `draw_req`=1 and `shuffle`=1 → all outputs at their reset values, `cards_left`=52, no `card_valid`.
- **Single draw:** from reset with `SEED`=16'hACE1, pulse `draw_req` → `card_valid` exactly 2 cycles later. Rank/suit/value match a bench LFSR model. `cards_left`=51. `value` obeys ace=11 and face=10.
- **Full deck:** 52 draws, each issued after the previous `card_valid` → 52 distinct (suit, rank) pairs, every latency ≤53 cycles, `deck_empty`=1 after the 52nd. A 53rd `draw_req` gives no `card_valid` and `busy` stays 0.
- **Busy drop:** pulse `draw_req` again during SEARCH → exactly one `card_valid` results, and `cards_left` decrements by 1.
- **Shuffle mid-draw:** with 51 cards dealt, `draw_req` then `shuffle` one cycle later → no `card_valid`, `cards_left`=52, card outputs unchanged, FSM IDLE. The next draw succeeds.
- **Simultaneous:** `shuffle` and `draw_req` in the same cycle with 10 cards dealt → `cards_left`=52, `busy` stays 0, no `card_valid`.

Source files
------------

// File: rtl/card_deck.sv
// Shuffled 52-card deck dispenser: LFSR-seeded probe into a used-card mask.
// Ports: clk/rst, shuffle/draw_req pulses in; card_valid, rank/suit/value, busy, deck_empty, cards_left out.
module card_deck #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic       draw_req,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [4:0] card_value,
  output logic       busy,
  output logic       deck_empty,
  output logic [5:0] cards_left
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [51:0] r_used;
  logic [5:0]  r_idx;
  logic [5:0]  r_left;
  logic        r_empty;
  logic        r_busy;
  logic        r_valid;
  logic [3:0]  r_rank;
  logic [1:0]  r_suit;
  logic [4:0]  r_value;

  logic [15:0] w_lfsr_nxt;
  logic [5:0]  w_start;
  logic [5:0]  w_idx_nxt;
  logic [5:0]  w_off;
  logic [3:0]  w_rank;
  logic [1:0]  w_suit;
  logic [4:0]  w_value;
  logic        w_hit;

  // Galois form, x^16+x^14+x^13+x^11+1
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]}
                    ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  // fold 52..63 onto 0..11
  assign w_start = (r_lfsr[5:0] >= 6'd52)
                 ? r_lfsr[5:0] - 6'd52
                 : r_lfsr[5:0];

  assign w_idx_nxt = (r_idx == 6'd51) ? 6'd0 : r_idx + 6'd1;
  assign w_hit     = ~r_used[r_idx];

  // index -> (suit, rank) by range compare
  always_comb begin
    w_suit = 2'd0;
    w_off  = r_idx + 6'd1;
    if (r_idx >= 6'd39) begin
      w_suit = 2'd3;
      w_off  = r_idx - 6'd38;
    end else if (r_idx >= 6'd26) begin
      w_suit = 2'd2;
      w_off  = r_idx - 6'd25;
    end else if (r_idx >= 6'd13) begin
      w_suit = 2'd1;
      w_off  = r_idx - 6'd12;
    end
  end

  assign w_rank = w_off[3:0];

  always_comb begin
    w_value = {1'b0, w_rank};
    if (w_rank == 4'd1) begin
      w_value = 5'd11;
    end else if (w_rank >= 4'd11) begin
      w_value = 5'd10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_used  <= '0;
      r_idx   <= '0;
      r_left  <= 6'd52;
      r_empty <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_rank  <= '0;
      r_suit  <= '0;
      r_value <= '0;
    end else if (shuffle) begin
      // abort any draw; card outputs keep last delivery
      r_state <= S_IDLE;
      r_used  <= '0;
      r_left  <= 6'd52;
      r_empty <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (draw_req && !r_empty) begin
            r_idx   <= w_start;
            r_busy  <= 1'b1;
            r_state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_hit) begin
            r_used[r_idx] <= 1'b1;
            r_rank  <= w_rank;
            r_suit  <= w_suit;
            r_value <= w_value;
            r_left  <= r_left - 6'd1;
            r_empty <= (r_left == 6'd1);
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= w_idx_nxt;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign card_valid = r_valid;
  assign card_rank  = r_rank;
  assign card_suit  = r_suit;
  assign card_value = r_value;
  assign busy       = r_busy;
  assign deck_empty = r_empty;
  assign cards_left = r_left;

endmodule
